ysyx_25030077_lsu_fsm: RTL
==========================

Name: ysyx_25030077_lsu_fsm

Overview:
Multi-cycle load/store unit between execute and writeback. It replaces the combinational memory-read path with a handshaked memory port. It accepts one memory operation from EXU and computes address = rs1 + imm. It issues a word-aligned bus request, waits for the response, then aligns and extends load data. The result goes to WBU through a valid/ready handshake.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT, 255, max cycles waiting for mem_rsp_valid before abort with error; 0 = no timeout

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  EXU offers an operation
in_ready  out  1  LSU can accept (high only in IDLE)
in_is_load  in  1  operation is a load
in_is_store  in  1  operation is a store (never both with is_load)
in_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_rs1_data  in  32  base address
in_rs2_data  in  32  store data
in_imm_data  in  32  sign-extended offset
in_rd  in  5  destination register
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  32  word-aligned address, {addr[31:2],2'b00}
mem_req_wen  out  1  1 = write
mem_req_wdata  out  32  store data shifted to byte lane
mem_req_wmask  out  4  byte enables
mem_rsp_valid  in  1  response/ack valid (one cycle)
mem_rsp_rdata  in  32  read word
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
out_rd  out  5  destination register
out_wen  out  1  register write enable (1 for error-free load with rd≠0)
out_data  out  32  aligned, extended load data; 0 for stores
out_err  out  1  access fault: timeout, or misalign when the optional feature is enabled

Behaviour:
- Reset (synchronous, active-high): state IDLE; in_ready=1; mem_req_valid=0; out_valid=0; out_* and mem_req_* registers = 0. Reset mid-transaction drops the operation; a late mem_rsp_valid is ignored in IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid && (is_load||is_store), latch inputs, the address and the byte offset off=addr[1:0], then go to REQ. in_valid with neither flag set is accepted and ignored; the state stays IDLE.
- REQ: mem_req_valid=1, request fields stable. On mem_req_ready, go to WAIT. mem_rsp_valid in the same cycle as mem_req_ready is legal: skip WAIT and capture the response directly into RESP.
- WAIT: count cycles. On mem_rsp_valid, capture rdata and go to RESP. If TIMEOUT≠0 and the count reaches TIMEOUT: go to RESP with out_err=1, out_wen=0, out_data=0.
- RESP: out_valid=1 and outputs held stable until out_ready. Then go to IDLE; in_ready rises the next cycle (no same-cycle bypass).
- Minimum latency with an always-ready memory and WBU: accept at cycle 0, request at 1, out_valid at 2, IDLE at 3.
- Store lanes:
  - B: wmask = 4'b0001<<off; wdata = {4{rs2[7:0]}}.
  - H: wmask = 4'b0011<<off; wdata = {2{rs2[15:0]}}.
  - W: wmask = 4'b1111; wdata = rs2.
- Load extraction: byte = rdata>>(8*off).
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - W passes the word through.
  - Reserved funct3 is treated as W.
- Misaligned access without the feature: H with off=3 uses the low byte of the shifted word only. Address bits [1:0] are still dropped on the bus.
- Address add wraps modulo 2^32.
- out_wen is 0 when rd=0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: H/HU with addr[0]=1, or W with addr[1:0]≠0, performs no bus request. The unit goes IDLE→RESP directly with out_err=1, out_wen=0, out_data=0.
- Undefined: no alignment check, behaviour as above.

Test Plan:
- LW, rs1=0x8000_0000, imm=4, memory returns 0xDEADBEEF with 0-cycle ready and 1-cycle rsp -> mem_req_addr=0x8000_0004; out_data=0xDEADBEEF; out_wen=1; out_valid 2 cycles after accept.
- LB at addr 0x8000_0003, rdata=0x80FF_0000 -> out_data=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU at 0x8000_0002 -> 0x0000_80FF.
- SB rs2=0x1234_56AB at addr 0x8000_0001 -> wen=1, wmask=4'b0010, wdata=0xABABABAB; out_wen=0. SH at offset 2 -> wmask=4'b1100.
- Back-pressure: mem_req_ready low for 5 cycles, then out_ready low for 3 cycles -> request fields and outputs held stable, in_ready=0 throughout, exactly one out handshake.
- Timeout: TIMEOUT=4 and mem_rsp_valid never asserted -> out_err=1 after 4 WAIT cycles, out_wen=0. Next op proceeds normally.
- Reset asserted in WAIT, then a stale mem_rsp_valid -> all outputs 0, in_ready=1, no out_valid produced. With LSU_MISALIGN_TRAP_EN, LW at 0x...02 -> no mem_req_valid, out_err=1.

Source files
------------

// File: rtl/ysyx_25030077_lsu_fsm.sv
// ysyx_25030077_lsu_fsm: multi-cycle load/store unit sitting between EXU and WBU.
//
// Takes one memory operation from EXU and forms its address as rs1 + imm.
// It then issues a word-aligned request on a valid/ready bus and waits for a
// single-cycle response. Load data is aligned and extended before being
// handed to WBU through a valid/ready handshake.
//
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN - when defined, H/HU with addr[0]=1 and W with
//   addr[1:0]!=0 skip the bus entirely and complete with out_err=1.
//   When undefined, no alignment check is done. Misaligned accesses use
//   the shifted word as-is, and the low address bits are dropped on the bus.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a new operation (in_ready=1)
// REQ   | bus request presented, fields held until mem_req_ready
// WAIT  | request accepted, counting down to timeout, waiting on rsp
// RESP  | result presented to WBU, held until out_ready

module ysyx_25030077_lsu_fsm #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm_data,
    input  logic [4:0]      in_rd,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Timeout down-counter width; a 1-bit counter is kept when the timeout is disabled.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              is_load_q, is_load_d;
    logic [4:0]        rd_q, rd_d;
    logic              req_wen_q, req_wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              out_wen_q, out_wen_d;
    logic              out_err_q, out_err_d;

    logic [XLEN-1:0]   addr_sum;
    logic              accept;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_wen;

    // Byte enables for a store; funct3[1:0] selects B/H, anything else is a full word.
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Store data replicated across lanes so the mask alone picks the target bytes.
    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
        logic [XLEN-1:0] d;
        case (f3[1:0])
            2'b00:   d = {4{rs2[7:0]}};
            2'b01:   d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

    // Shift the read word down by the byte offset, then sign/zero extend by funct3.
    // Reserved encodings fall through to the full word.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{(XLEN-8){sh[7]}},   sh[7:0]};
            3'b001:  r = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b100:  r = {{(XLEN-8){1'b0}},    sh[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}},   sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfwords need an even address and words a 4-byte aligned one; bytes never fault.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3[1:0])
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction
`endif

    assign addr_sum = in_rs1_data + in_imm_data;
    assign accept   = in_valid && (in_is_load || in_is_store);

    // Result fields for a captured response: stores write nothing back, rd=0 is never written.
    assign rsp_data = is_load_q ? load_ext(f3_q, off_q, mem_rsp_rdata) : '0;
    assign rsp_wen  = is_load_q && (rd_q != 5'd0);

    // Next-state and datapath update for the IDLE/REQ/WAIT/RESP sequence.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        f3_d       = f3_q;
        is_load_d  = is_load_q;
        rd_d       = rd_q;
        req_wen_d  = req_wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_wen_d  = out_wen_q;
        out_err_d  = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d     = addr_sum;
                    off_d      = addr_sum[1:0];
                    f3_d       = in_funct3;
                    is_load_d  = in_is_load;
                    rd_d       = in_rd;
                    req_wen_d  = in_is_store;
                    wmask_d    = in_is_store ? store_mask(in_funct3, addr_sum[1:0]) : 4'b0000;
                    wdata_d    = in_is_store ? store_data(in_funct3, in_rs2_data) : '0;
                    out_data_d = '0;
                    out_wen_d  = 1'b0;
                    out_err_d  = 1'b0;
                    state_d    = S_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned(in_funct3, addr_sum[1:0])) begin
                        out_err_d = 1'b1;
                        state_d   = S_RESP;
                    end
`endif
                end
            end

            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d = CW'(TIMEOUT);
                    // A response arriving with the request acceptance skips WAIT.
                    if (mem_rsp_valid) begin
                        out_data_d = rsp_data;
                        out_wen_d  = rsp_wen;
                        out_err_d  = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (mem_rsp_valid) begin
                    out_data_d = rsp_data;
                    out_wen_d  = rsp_wen;
                    out_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CW'(1)) begin
                        out_data_d = '0;
                        out_wen_d  = 1'b0;
                        out_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end

            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            is_load_q  <= 1'b0;
            rd_q       <= 5'd0;
            req_wen_q  <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= 4'b0000;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_wen_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            is_load_q  <= is_load_d;
            rd_q       <= rd_d;
            req_wen_q  <= req_wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_wen_q  <= out_wen_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign out_valid     = (state_q == S_RESP);
    assign out_rd        = rd_q;
    assign out_wen       = out_wen_q;
    assign out_data      = out_data_q;
    assign out_err       = out_err_q;

endmodule
